// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for the multicycle MIPS datapath. One instruction at a
// time is walked through fetch / decode / execute / memory / writeback, and
// every datapath mux select and write enable is driven from here. The ALU
// decoder and the PC write-enable combine are embedded. FETCH, MEMRD and
// MEMWR hold until the shared memory handshake (mem_ready) completes.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous, active-low reset
//   op, funct   - instruction[31:26] and instruction[5:0] from the IR
//   zero        - ALU zero flag (used only for beq)
//   mem_ready   - memory finished the current access this cycle
//   memtoreg    - writeback source (1 = data register, 0 = ALU out)
//   regdst      - destination register (1 = rd, 0 = rt)
//   iord        - memory address source (1 = ALU out, 0 = PC)
//   pcsrc       - next PC source (00 ALU result, 01 ALU out, 10 jump target)
//   alusrca     - ALU A source (1 = register A, 0 = PC)
//   alusrcb     - ALU B source (00 B, 01 +4, 10 imm, 11 imm<<2)
//   alucontrol  - ALU operation
//   irwrite, memwrite, regwrite, pcen - write enables
//   illegal_op  - one-cycle pulse in DECODE on an unsupported opcode
//   state       - current state, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // Moore control word. 'fetch' qualifies irwrite/pcwrite with mem_ready,
    // 'jump' is the unconditional PC write, 'branch' is gated by zero.
    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       memtoreg;
        logic       regdst;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       jump;
        logic       fetch;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctl_q;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.alusrcb = 2'b01; c.fetch = 1'b1; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BRANCH:  begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  c.regwrite = 1'b1;
            JUMP:    begin c.pcsrc = 2'b10; c.jump = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic supported(input logic [5:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) ||
               (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // The control word is registered together with the state, decoded from
    // the state being entered, so the outputs come straight from flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            ctl_q   <= decode_ctrl(FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= decode_ctrl(state_d);
        end
    end

    // Output stage: everything is forced low while reset is held, so the
    // datapath sees no write even before the first reset edge.
    always_comb begin
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        pcen       = 1'b0;
        illegal_op = 1'b0;
        state      = 4'd0;
        if (reset) begin
            memtoreg   = ctl_q.memtoreg;
            regdst     = ctl_q.regdst;
            iord       = ctl_q.iord;
            pcsrc      = ctl_q.pcsrc;
            alusrca    = ctl_q.alusrca;
            alusrcb    = ctl_q.alusrcb;
            memwrite   = ctl_q.memwrite;
            regwrite   = ctl_q.regwrite;
            irwrite    = ctl_q.fetch & mem_ready;
            pcen       = (ctl_q.fetch & mem_ready) | ctl_q.jump |
                         (ctl_q.branch & zero);
            illegal_op = (state_q == DECODE) && !supported(op);
            state      = state_q;
            case (ctl_q.aluop)
                2'b00: alucontrol = 3'b010;
                2'b01: alucontrol = 3'b110;
                2'b10: begin
                    case (funct)
                        6'b100000: alucontrol = 3'b010;
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b010;
                    endcase
                end
                default: alucontrol = 3'b010;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Self-checking bench for mips_multicycle_ctrl. A reference model tracks
// each instruction as a list of visited states and derives the expected
// outputs of every cycle from the per-state control table. Directed table
// vectors, hand-written wait/reset sequences and a randomized run are all
// compared cycle by cycle against that model.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       memtoreg, regdst, iord, alusrca;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic       irwrite, memwrite, regwrite, pcen, illegal_op;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .iord       (iord),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model position inside the current instruction's state list.
    int idx = 0;

    // Per-instruction observation counters.
    int n_pcen, n_regw, n_memw, n_ill, n_irw, n_memw_iord;
    logic [2:0] last_alu;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [3:0] cycles;
        logic [3:0] n_pcen;
        logic [3:0] n_regw;
        logic [3:0] n_memw;
        logic [3:0] n_ill;
        logic [3:0] alu2;   // alucontrol in 3rd cycle, 4'hF = not checked
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp,
                     $time);
        end
    endtask

    function automatic logic is_supported(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b001000, 6'b000010};
    endfunction

    // States visited by an instruction with memory always ready.
    function automatic int seq_step(input logic [5:0] o, input int i,
                                    output int len);
        int q[$];
        case (o)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            default:   q = '{0, 1};
        endcase
        len = q.size();
        return (i < len) ? q[i] : 0;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [1:0] aop,
                                           input logic [5:0] f);
        if (aop == 2'b00) return 3'b010;
        if (aop == 2'b01) return 3'b110;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector, same packing as dut_vec().
    function automatic logic [19:0] exp_vec(input int s, input logic rst,
                                            input logic [5:0] o,
                                            input logic [5:0] f,
                                            input logic z, input logic mr);
        logic m2r, rd, io, asa, irw, mw, rw, pcw, br, ill;
        logic [1:0] pcs, asb, aop;
        m2r = 0; rd = 0; io = 0; asa = 0; irw = 0; mw = 0; rw = 0;
        pcw = 0; br = 0; ill = 0; pcs = 0; asb = 0; aop = 0;
        if (!rst) return '0;
        case (s)
            0:  begin asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; ill = !is_supported(o); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {m2r, rd, io, pcs, asa, asb, alu_ref(aop, f), irw, mw, rw,
                pcw | (br & z), ill, 4'(s)};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, alucontrol,
                irwrite, memwrite, regwrite, pcen, illegal_op, state};
    endfunction

    task automatic clear_counts();
        n_pcen = 0; n_regw = 0; n_memw = 0; n_ill = 0; n_irw = 0;
        n_memw_iord = 0;
    endtask

    // One clock: compare at the falling edge, advance the model on the
    // rising edge using the inputs that were present at that edge.
    task automatic tick(input string tag);
        int s, len;
        @(negedge clk);
        s = seq_step(op, idx, len);
        check(tag, 32'(dut_vec()), 32'(exp_vec(s, reset, op, funct, zero,
                                               mem_ready)));
        n_pcen      += int'(pcen);
        n_regw      += int'(regwrite);
        n_memw      += int'(memwrite);
        n_ill       += int'(illegal_op);
        n_irw       += int'(irwrite);
        n_memw_iord += int'(memwrite & iord);
        last_alu     = alucontrol;
        @(posedge clk);
        if (!reset) idx = 0;
        else if ((s == 0 || s == 3 || s == 5) && !mem_ready) idx = idx;
        else idx = (idx + 1 == len) ? 0 : idx + 1;
        #1;
    endtask

    // Run one instruction from FETCH back to FETCH. wf / wm are the numbers
    // of not-ready cycles inserted in FETCH and in MEMRD/MEMWR.
    task automatic run_instr(input string tag, input logic [5:0] o,
                             input logic [5:0] f, input logic z,
                             input int wf, input int wm,
                             output int cycles, output logic [2:0] alu2);
        int  n;
        bit  left;
        n = 0; left = 0; alu2 = 3'b000;
        op = o; funct = f; zero = z;
        clear_counts();
        do begin
            if (state == 4'd0 && wf > 0) begin mem_ready = 0; wf--; end
            else if ((state == 4'd3 || state == 4'd5) && wm > 0) begin
                mem_ready = 0; wm--;
            end else mem_ready = 1;
            tick(tag);
            n++;
            if (n == 3) alu2 = last_alu;
            if (state != 4'd0) left = 1;
        end while (!(left && state == 4'd0) && n < 40);
        check({tag, "_bounded"}, 32'(n < 40), 32'd1);
        cycles = n;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [2:0] a2;
        logic [5:0] rops[8];
        logic [5:0] rfun[6];

        vecs[0]  = '{6'b100011, 6'd0,      1'b0, 4'd5, 4'd1, 4'd1, 4'd0, 4'd0, 4'h2};
        vecs[1]  = '{6'b101011, 6'd0,      1'b0, 4'd4, 4'd1, 4'd0, 4'd1, 4'd0, 4'h2};
        vecs[2]  = '{6'b000000, 6'b101010, 1'b0, 4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 4'h7};
        vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 4'h6};
        vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 4'h0};
        vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 4'h1};
        vecs[6]  = '{6'b000000, 6'b000111, 1'b0, 4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 4'h2};
        vecs[7]  = '{6'b000100, 6'd0,      1'b1, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 4'h6};
        vecs[8]  = '{6'b000100, 6'd0,      1'b0, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'h6};
        vecs[9]  = '{6'b001000, 6'd0,      1'b0, 4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 4'h2};
        vecs[10] = '{6'b000010, 6'd0,      1'b0, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 4'h2};
        vecs[11] = '{6'b111111, 6'd0,      1'b0, 4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'hF};

        // Reset held for two edges, then released into a normal fetch.
        reset = 0; mem_ready = 1; op = 6'b000000; funct = 6'b100000;
        tick("reset_0");
        tick("reset_1");
        check("reset_enables", 32'({irwrite, pcen, memwrite, regwrite,
                                    illegal_op}), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        reset = 1;
        #1;
        check("release_irwrite", 32'(irwrite), 32'd1);
        check("release_pcen", 32'(pcen), 32'd1);
        tick("release_fetch");
        check("release_state", 32'(state), 32'd1);
        for (int i = 0; i < 10 && idx != 0; i++) tick("release_finish");

        // Table vectors, memory always ready.
        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_instr(t, vecs[i].op, vecs[i].funct, vecs[i].zero, 0, 0,
                      cyc, a2);
            check({t, "_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
            check({t, "_pcen"}, 32'(n_pcen), 32'(vecs[i].n_pcen));
            check({t, "_regwrite"}, 32'(n_regw), 32'(vecs[i].n_regw));
            check({t, "_memwrite"}, 32'(n_memw), 32'(vecs[i].n_memw));
            check({t, "_illegal"}, 32'(n_ill), 32'(vecs[i].n_ill));
            if (vecs[i].alu2 != 4'hF)
                check({t, "_alu"}, 32'(a2), 32'(vecs[i].alu2[2:0]));
        end

        // lw with two not-ready cycles in MEMRD.
        run_instr("lw_wait", 6'b100011, 6'd0, 1'b0, 0, 2, cyc, a2);
        check("lw_wait_cycles", 32'(cyc), 32'd7);
        check("lw_wait_regwrite", 32'(n_regw), 32'd1);

        // sw with three not-ready cycles in MEMWR: memwrite held 4 cycles.
        run_instr("sw_wait", 6'b101011, 6'd0, 1'b0, 0, 3, cyc, a2);
        check("sw_wait_cycles", 32'(cyc), 32'd7);
        check("sw_wait_memwrite", 32'(n_memw), 32'd4);
        check("sw_wait_iord", 32'(n_memw_iord), 32'd4);

        // addi with two not-ready cycles in FETCH.
        run_instr("addi_fwait", 6'b001000, 6'd0, 1'b0, 2, 0, cyc, a2);
        check("addi_fwait_cycles", 32'(cyc), 32'd6);
        check("addi_fwait_irwrite", 32'(n_irw), 32'd1);
        check("addi_fwait_pcen", 32'(n_pcen), 32'd1);

        // Reset asserted in the middle of a stalled sw.
        op = 6'b101011; funct = 6'd0; zero = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) tick("sw_abort_pre");
        check("sw_abort_in_memwr", 32'(state), 32'd5);
        mem_ready = 0;
        tick("sw_abort_stall");
        reset = 0;
        #1;
        check("sw_abort_memwrite_now", 32'(memwrite), 32'd0);
        tick("sw_abort_reset");
        reset = 1;
        #1;
        check("sw_abort_state", 32'(state), 32'd0);
        run_instr("after_abort", 6'b100011, 6'd0, 1'b0, 0, 0, cyc, a2);
        check("after_abort_cycles", 32'(cyc), 32'd5);

        // Randomized run against the model, including stray resets and
        // mem_ready toggling in states that must ignore it.
        rops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                 6'b001000, 6'b000010, 6'b111111, 6'b001101};
        rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                 6'b101010, 6'b011000};
        for (int c = 0; c < 3000; c++) begin
            if (idx == 0) begin
                op    = rops[$urandom_range(0, 7)];
                funct = rfun[$urandom_range(0, 5)];
            end
            zero      = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 63) != 0);
            tick("random");
        end
        reset = 1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control unit for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable. It embeds the ALU decoder and the PC-enable logic. Fetch and data-memory states wait on a shared memory-ready handshake so the core can run against slow memory.

## Interface
Parameters: none.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `op` input 6: instruction[31:26] from the instruction register.
- `funct` input 6: instruction[5:0] from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current access this cycle.
- `memtoreg` output 1: register writeback source; 1 = data register, 0 = ALU out.
- `regdst` output 1: destination register; 1 = rd, 0 = rt.
- `iord` output 1: memory address source; 1 = ALU out, 0 = PC.
- `pcsrc` output 2: next-PC source; 00 = ALU result, 01 = ALU out, 10 = jump target.
- `alusrca` output 1: ALU A source; 1 = register A, 0 = PC.
- `alusrcb` output 2: ALU B source; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `alucontrol` output 3: ALU operation.
- `irwrite` output 1: instruction register write enable.
- `memwrite` output 1: memory write enable.
- `regwrite` output 1: register file write enable.
- `pcen` output 1: PC write enable.
- `illegal_op` output 1: one-cycle pulse on an unsupported opcode.
- `state` output 4: current state, for debug.

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Codes 12–15 are unreachable; if entered, the next state is FETCH.

Outputs are Moore-decoded from `state`, except `pcen` and `alucontrol`. Any output not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=`mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw → MEMRD; sw → MEMWR.
- MEMRD: iord=1. Stay while `mem_ready`=0; go to MEMWB when it is 1.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1 (held for the whole state). Stay while `mem_ready`=0; go to FETCH when it is 1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 → ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
- JUMP: pcsrc=10, pcwrite=1 → FETCH.

`pcen` = pcwrite | (branch & `zero`).

ALU decoder (`alucontrol`):
- aluop 00 → 010 (add); aluop 01 → 110 (sub).
- aluop 10, decoded by `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other `funct` → 010.

Reset:
- `reset`=0 at a rising edge sets `state` to FETCH, including mid-instruction (an in-progress sw wait is abandoned).
- While `reset`=0, the enables `irwrite`, `pcen`, `memwrite`, `regwrite` and `illegal_op` are forced to 0 combinationally, and every other output is 0.
- Once `reset` is 1, the first FETCH behaves normally.

## Timing
- Cycle counts with `mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- `illegal_op` is high only during the single DECODE cycle of an unsupported opcode.
- `zero` is sampled only in BRANCH, and only combinationally through `pcen`.
- A `reset` assertion takes priority over any transition in the same cycle.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `mem_ready`=1 → `state`=0 and all enables 0 during reset. After release: `irwrite`=1 and `pcen`=1 in the first cycle, then `state`=1.
- lw (op=100011), `mem_ready`=1 → states 0,1,2,3,4,0. `regwrite`=1 and `memtoreg`=1 only in state 4. Repeat with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total.
- sw (op=101011), `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 consecutive cycles with `iord`=1, then back to FETCH.
- R-type: funct=101010 → `alucontrol`=111 in EXECUTE; funct=100010 → 110. `regwrite`=1 with `regdst`=1 in ALUWB.
- beq (op=000100): `zero`=1 → `pcen`=1 in BRANCH; `zero`=0 → `pcen`=0. Both take 3 cycles. j (op=000010) → `pcen`=1 with `pcsrc`=10.
- Illegal op=111111 → `illegal_op`=1 for exactly one cycle in DECODE, then `state`=0, with no `regwrite` or `memwrite`. Assert `reset`=0 mid-MEMWR → `state`=0 on the next edge and `memwrite`=0 immediately.
